// File: rtl/mult_rr_scheduler_pkg.sv
// Shared types and constants for the round-robin multiplier scheduler:
// scheduler state encoding, operand/result widths and an index-to-one-hot helper.
package mult_rr_scheduler_pkg;

    localparam int OP_W_DEF  = 3;
    localparam int RES_W_DEF = 2 * OP_W_DEF;
    localparam int MAX_REQ   = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_BUSY    = 3'd2,
        S_CAPTURE = 3'd3,
        S_RESPOND = 3'd4
    } state_t;

    function automatic logic [MAX_REQ-1:0] idx_to_onehot(input logic [2:0] idx);
        logic [MAX_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mult_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first active request searching
// ptr+1, ptr+2, ... modulo N_REQ; found_o is low when no request is active.
module mult_rr_scheduler_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic             found_o
);

    logic [IW-1:0] cand;

    always_comb begin
        grant_o = '0;
        found_o = 1'b0;
        cand    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IW'((int'(ptr_i) + k) % N_REQ);
            if (!found_o && req_i[cand]) begin
                grant_o[cand] = 1'b1;
                found_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one sequential multiplier among N_REQ requesters.
// Define MULT_TIMEOUT_EN to add a watchdog that abandons a job stuck in BUSY.
module mult_rr_scheduler
    import mult_rr_scheduler_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int OP_W           = OP_W_DEF,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  SYS_CLOCK,
    input  logic                  SYS_RESET_N,
    input  logic [N_REQ-1:0]      REQ,
    input  logic [N_REQ*OP_W-1:0] REQ_A,
    input  logic [N_REQ*OP_W-1:0] REQ_B,
    output logic [N_REQ-1:0]      GRANT,
    output logic [N_REQ-1:0]      DONE,
    output logic [2*OP_W-1:0]     RESULT,
    output logic                  ERR,
    output logic                  MULT_GO,
    output logic [OP_W-1:0]       MULT_A,
    output logic [OP_W-1:0]       MULT_B,
    input  logic                  MULT_READY,
    input  logic                  MULT_RES,
    input  logic [2*OP_W-1:0]     MULT_PRODUCT
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int RW = 2 * OP_W;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     gidx_q, gidx_d;
    logic [OP_W-1:0]   a_q, a_d, b_q, b_d;
    logic [RW-1:0]     result_q, result_d;
    logic              mult_go;

    logic [N_REQ-1:0]  pick_oh;
    logic              pick_found;
    logic [IW-1:0]     pick_idx;
    logic [OP_W-1:0]   a_arr [N_REQ];
    logic [OP_W-1:0]   b_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = REQ_A[gi*OP_W +: OP_W];
            assign b_arr[gi] = REQ_B[gi*OP_W +: OP_W];
        end
    endgenerate

    mult_rr_scheduler_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req_i   (REQ),
        .ptr_i   (ptr_q),
        .grant_o (pick_oh),
        .found_o (pick_found)
    );

    always_comb begin
        pick_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (pick_oh[k]) pick_idx = IW'(k);
        end
    end

`ifdef MULT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          timeout;

    assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Counter restarts on every entry to BUSY and counts BUSY cycles only.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_ISSUE)     cnt_d = '0;
        else if (state_q == S_BUSY) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge SYS_CLOCK) begin
        if (!SYS_RESET_N) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign ERR = (state_q == S_RESPOND) && err_q;
`else
    assign ERR = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        gidx_d   = gidx_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        mult_go  = 1'b0;
`ifdef MULT_TIMEOUT_EN
        err_d    = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d = N_REQ'(idx_to_onehot(3'(pick_idx)));
                    gidx_d  = pick_idx;
                    a_d     = a_arr[pick_idx];
                    b_d     = b_arr[pick_idx];
`ifdef MULT_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // GO is only offered while the multiplier is idle, so it is a single-cycle pulse.
                if (MULT_READY) begin
                    mult_go = 1'b1;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (MULT_RES) begin
                    state_d = S_CAPTURE;
                end
`ifdef MULT_TIMEOUT_EN
                else if (timeout) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_RESPOND;
                end
`endif
            end
            S_CAPTURE: begin
                result_d = MULT_PRODUCT;
                state_d  = S_RESPOND;
            end
            S_RESPOND: begin
                ptr_d   = gidx_q;
                grant_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge SYS_CLOCK) begin
        if (!SYS_RESET_N) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            ptr_q    <= IW'(N_REQ - 1);
            gidx_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    assign GRANT   = grant_q;
    assign DONE    = (state_q == S_RESPOND) ? grant_q : '0;
    assign RESULT  = result_q;
    assign MULT_GO = mult_go;
    assign MULT_A  = a_q;
    assign MULT_B  = b_q;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Scoreboard bench for mult_rr_scheduler with a behavioural sequential multiplier
// (states 000 idle, 001 load, 010 compute x max(B,1), 011 RES) behind it.
module tb_mult_rr_scheduler;

    localparam int N  = 4;
    localparam int W  = 3;
    localparam int RW = 6;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*W-1:0]  req_a, req_b;
    logic [N-1:0]    grant, done;
    logic [RW-1:0]   result;
    logic            err, mult_go, mult_ready, mult_res;
    logic [W-1:0]    mult_a, mult_b;
    logic [RW-1:0]   m_f;

    always #5 clk = ~clk;

    mult_rr_scheduler #(.N_REQ(N), .OP_W(W), .TIMEOUT_CYCLES(16)) dut (
        .SYS_CLOCK    (clk),
        .SYS_RESET_N  (rst_n),
        .REQ          (req),
        .REQ_A        (req_a),
        .REQ_B        (req_b),
        .GRANT        (grant),
        .DONE         (done),
        .RESULT       (result),
        .ERR          (err),
        .MULT_GO      (mult_go),
        .MULT_A       (mult_a),
        .MULT_B       (mult_b),
        .MULT_READY   (mult_ready),
        .MULT_RES     (mult_res),
        .MULT_PRODUCT (m_f)
    );

    // Behavioural multiplier
    logic [2:0]   m_state;
    logic [W-1:0] m_a, m_b, m_cnt;
    logic         force_nr, res_mask;

    assign mult_ready = (m_state == 3'b000) && !force_nr;
    assign mult_res   = (m_state == 3'b011) && !res_mask;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_state <= 3'b000;
            m_f     <= '0;
            m_cnt   <= '0;
            m_a     <= '0;
            m_b     <= '0;
        end else begin
            case (m_state)
                3'b000: if (mult_go) begin
                    m_a     <= mult_a;
                    m_b     <= mult_b;
                    m_state <= 3'b001;
                end
                3'b001: begin
                    m_cnt   <= (m_b <= 3'd1) ? 3'd1 : m_b;
                    m_state <= 3'b010;
                end
                3'b010: begin
                    if (m_cnt == 3'd1) m_state <= 3'b011;
                    m_cnt <= m_cnt - 3'd1;
                end
                default: begin
                    m_f     <= RW'(m_a) * RW'(m_b);
                    m_state <= 3'b000;
                end
            endcase
        end
    end

    // Requester model: REQ[i] is high while requests issued outnumber those served or cancelled.
    int issue_cnt  [N];
    int served_cnt [N];
    int cancel_cnt [N];

    always_comb begin
        for (int i = 0; i < N; i++) req[i] = (issue_cnt[i] > served_cnt[i] + cancel_cnt[i]);
    end

    typedef struct {
        int idx;
        int res;
        int err;
    } exp_t;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   done_count = 0;
    int   go_count   = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input int a, input int b);
        req_a[i*W +: W] = W'(a);
        req_b[i*W +: W] = W'(b);
        issue_cnt[i]++;
    endtask

    task automatic push(input int i, input int res, input int e);
        exp_t x;
        x.idx = i;
        x.res = res;
        x.err = e;
        sb.push_back(x);
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (done_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (done_count < target) begin
            miscompares++;
            $display("FAIL wait_done: done_count=%0d, expected %0d within %0d cycles", done_count, target, budget);
        end
    endtask

    // Cycles from the negedge a request is raised to the negedge DONE is seen.
    task automatic measure(input string name, input int exp_cyc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done == '0 && n < 100);
        check(name, n, exp_cyc);
    endtask

    // Monitor: pops the scoreboard on every DONE
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                go_count = 0;
            end else begin
                if (mult_go) go_count++;
                if (done != '0) begin
                    $display("DONE onehot=%b result=%0d err=%0d go_pulses=%0d", done, result, err, go_count);
                    done_count++;
                    for (int i = 0; i < N; i++) if (done[i]) served_cnt[i]++;
                    if (sb.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_done: DONE=%b, expected no DONE", done);
                    end else begin
                        e = sb.pop_front();
                        check("done_onehot", int'(done), 1 << e.idx);
                        check("result", int'(result), e.res);
                        check("err", int'(err), e.err);
                        check("go_per_job", go_count, 1);
                    end
                    go_count = 0;
                end
            end
        end
    end

    initial begin
        int g;
        for (int i = 0; i < N; i++) begin
            issue_cnt[i]  = 0;
            served_cnt[i] = 0;
            cancel_cnt[i] = 0;
        end
        rst_n    = 1'b0;
        force_nr = 1'b0;
        res_mask = 1'b0;
        req_a    = '0;
        req_b    = '0;
        repeat (3) @(negedge clk);
        check("rst_grant",  int'(grant),   0);
        check("rst_done",   int'(done),    0);
        check("rst_go",     int'(mult_go), 0);
        check("rst_err",    int'(err),     0);
        check("rst_result", int'(result),  0);
        check("rst_mult_a", int'(mult_a),  0);
        check("rst_mult_b", int'(mult_b),  0);
        rst_n = 1'b1;

        // Contention: all four at once, served 0,1,2,3
        @(negedge clk);
        set_req(0, 1, 1); set_req(1, 2, 3); set_req(2, 7, 7); set_req(3, 0, 6);
        push(0, 1, 0); push(1, 6, 0); push(2, 49, 0); push(3, 0, 0);
        wait_done(4, 200);

        // Single requests with latency checks
        @(negedge clk);
        set_req(0, 3, 5);
        push(0, 15, 0);
        measure("latency_b5", 10);
        @(negedge clk);
        check("grant_after_done", int'(grant), 0);
        set_req(0, 6, 1);
        push(0, 6, 0);
        measure("latency_b1", 6);

        // Multiplier not ready for 5 ISSUE cycles
        @(negedge clk);
        force_nr = 1'b1;
        set_req(1, 4, 3);
        push(1, 12, 0);
        g = 0;
        repeat (5) begin
            @(negedge clk);
            if (mult_go) g++;
        end
        check("go_while_not_ready", g, 0);
        @(posedge clk);
        #1 force_nr = 1'b0;
        @(negedge clk);
        #1 check("go_on_first_ready", int'(mult_go), 1);
        wait_done(7, 100);

        // Fairness: requester 2 keeps requesting, 0 arrives mid-job
        @(negedge clk);
        set_req(2, 5, 3); set_req(2, 5, 3);
        push(2, 15, 0); push(0, 4, 0); push(2, 15, 0);
        repeat (3) @(negedge clk);
        check("grant_busy_2", int'(grant), 4);
        set_req(0, 2, 2);
        wait_done(10, 200);

        // Reset while a job is in BUSY
        @(negedge clk);
        set_req(1, 7, 6);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        cancel_cnt[1]++;
        @(negedge clk);
        check("midrst_grant",  int'(grant),   0);
        check("midrst_done",   int'(done),    0);
        check("midrst_go",     int'(mult_go), 0);
        check("midrst_result", int'(result),  0);
        check("midrst_mult_a", int'(mult_a),  0);
        rst_n = 1'b1;
        @(negedge clk);
        set_req(0, 1, 2); set_req(3, 3, 3);
        push(0, 2, 0); push(3, 9, 0);
        wait_done(12, 200);

`ifdef MULT_TIMEOUT_EN
        // Watchdog: RES never seen, 16 BUSY cycles then DONE with ERR
        @(negedge clk);
        res_mask = 1'b1;
        set_req(0, 5, 2); set_req(1, 2, 3);
        push(0, 0, 1); push(1, 6, 0);
        measure("timeout_latency", 18);
        res_mask = 1'b0;
        wait_done(14, 200);
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mult_rr_scheduler.md
Name: mult_rr_scheduler

Overview:
- Round-robin scheduler that shares one 3x3 sequential unsigned multiplier (FSM plus ALU/counter datapath) among N_REQ requesters.
- Accepts operand requests, issues GO when the multiplier reports READY, and waits for the RES state. It then captures the product from the F register and returns it to the granted requester with a one-cycle DONE pulse.
- Sits between the requester clients and the multiplier top level.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- OP_W, 3, operand width.
- TIMEOUT_CYCLES, 16, watchdog limit on cycles in BUSY (used only with MULT_TIMEOUT_EN).

Ports:
- SYS_CLOCK  in  1  system clock; all logic on rising edge.
- SYS_RESET_N  in  1  synchronous, active-low reset.
- REQ  in  N_REQ  request per requester; held high until its DONE.
- REQ_A  in  N_REQ*OP_W  packed operand A; slice i belongs to requester i; stable while REQ[i] is high.
- REQ_B  in  N_REQ*OP_W  packed operand B; same rules as REQ_A.
- GRANT  out  N_REQ  one-hot; marks the requester currently being served.
- DONE  out  N_REQ  one-cycle pulse to the served requester.
- RESULT  out  2*OP_W  product; valid in the DONE cycle; holds until the next capture.
- ERR  out  1  timeout flag; pulses with DONE.
- MULT_GO  out  1  GO to the multiplier FSM.
- MULT_A  out  OP_W  operand A to the multiplier.
- MULT_B  out  OP_W  operand B to the multiplier.
- MULT_READY  in  1  multiplier FSM READY (idle state).
- MULT_RES  in  1  multiplier FSM RES (F register load cycle).
- MULT_PRODUCT  in  2*OP_W  multiplier F register output.

Behaviour:
- Reset (sampled on SYS_CLOCK while SYS_RESET_N=0):
  - state=IDLE; GRANT, DONE, MULT_GO, ERR, RESULT, MULT_A, MULT_B all 0.
  - Round-robin pointer PTR=N_REQ-1, so requester 0 has first priority.
  - Reset mid-operation drops the in-flight job: no DONE is produced and requesters must re-request.
- States: IDLE, ISSUE, BUSY, CAPTURE, RESPOND.
- IDLE:
  - If any REQ is high, select the first set bit searching PTR+1, PTR+2, ... modulo N_REQ.
  - Register GRANT one-hot; latch MULT_A/MULT_B from that requester's slices; go to ISSUE.
  - If no REQ is high, stay in IDLE.
- ISSUE:
  - MULT_GO=1 only while MULT_READY=1; on that cycle go to BUSY.
  - While MULT_READY=0, hold MULT_GO=0 and stay in ISSUE.
  - MULT_GO is never high for more than one cycle per job.
- BUSY:
  - Wait for MULT_RES=1, then go to CAPTURE.
  - MULT_A/MULT_B stay stable throughout.
- CAPTURE:
  - The F register loaded at the end of the RES cycle is now valid.
  - RESULT <= MULT_PRODUCT; go to RESPOND.
- RESPOND:
  - DONE[granted]=1 for exactly one cycle; RESULT is valid.
  - PTR <= granted index; GRANT cleared on exit; go to IDLE.
- Minimum latency from request to DONE: IDLE select → ISSUE → BUSY (FSM states 001, 010*, 011) → CAPTURE → RESPOND.
  - B<=1 case: 6 cycles.
  - Larger B: +1 cycle per extra compute iteration.
- Request rules:
  - REQ changes of non-granted requesters are ignored until the next IDLE.
  - Dropping REQ of the granted requester mid-job does not abort the job; DONE is still pulsed.
- One job in flight at a time; no pipelining.
- Arithmetic: RESULT width is 2*OP_W, so there is no overflow (7*7=49 fits in 6 bits).
- Simultaneous requests are resolved purely by the round-robin pointer.
- A requester that keeps REQ high after DONE re-enters arbitration in the next IDLE cycle. It is served again only after every other pending requester has been served.

Optional Feature:
- Macro: MULT_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle.
  - When the count reaches TIMEOUT_CYCLES with no MULT_RES: go to RESPOND with RESULT=0, ERR=1 and DONE pulsed; PTR advances as normal.
- Undefined:
  - No counter; BUSY waits indefinitely.
  - ERR is tied to 0.

Decomposition:
- Shared package: state enum type; OP_W/result-width constants; a GRANT-index-to-one-hot function.
- Sub-module rr_pick:
  - Combinational round-robin priority picker.
  - Inputs: REQ vector and PTR.
  - Outputs: one-hot grant and a found flag.

Test Plan:
- Single request: REQ=4'b0001, A=3, B=5 → MULT_GO pulses once; DONE[0] pulses; RESULT=15; GRANT returns to 0.
- Contention: REQ=4'b1111, pairs (1,1),(2,3),(7,7),(0,6) → DONE order 0,1,2,3; RESULTs 1,6,49,0; exactly one GO per job.
- Fairness: REQ[2] held high continuously while REQ[0] rises mid-job on 2 → next grant is 0, then 2.
- Not ready: MULT_READY held 0 for 5 cycles in ISSUE → MULT_GO stays 0 and asserts on the first READY=1 cycle.
- Reset mid-BUSY: SYS_RESET_N=0 for one cycle → all outputs 0; no DONE for the aborted job; requester 0 served first afterwards.
- With MULT_TIMEOUT_EN: MULT_RES never asserted → after 16 BUSY cycles, DONE and ERR pulse with RESULT=0; the next requester is served.
